seg7_capture_decoder: RTL and testbench



---
 rtl/seg7_capture_decoder_if.sv | 42 ++++
 rtl/seg7_capture_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_decoder_if.sv
// Segment capture bus: active-low segment input plus the result handshake.
// Optional macro SEG7_ERR_COUNT_EN adds the err_count field.
interface seg7_capture_decoder_if;
  logic [6:0] seg_n;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bcd;
  logic       out_blank;
  logic       out_err;
  logic       overflow;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  // Decoder side: samples the segment bus, produces results
  modport master (
    input  seg_n,
    input  out_ready,
    output out_valid,
    output out_bcd,
    output out_blank,
    output out_err,
`ifdef SEG7_ERR_COUNT_EN
    output err_count,
`endif
    output overflow
  );

  // Consumer side: drives the segment bus and takes results
  modport slave (
    output seg_n,
    output out_ready,
    input  out_valid,
    input  out_bcd,
    input  out_blank,
    input  out_err,
`ifdef SEG7_ERR_COUNT_EN
    input  err_count,
`endif
    input  overflow
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples an active-low 7-segment bus, waits for the
// pattern to stay stable, decodes it back to BCD / blank / error and holds
// the result in a one-entry register with a valid/ready handshake.
// Optional macro SEG7_ERR_COUNT_EN adds a saturating 8-bit error counter.
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  seg7_capture_decoder_if.master bus
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK_PAT  = 7'b1111111;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } result_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] sample;
  logic [7:0] stable_count;
  logic [7:0] count_next;
  logic [6:0] last_pattern;
  logic       last_empty;
  logic       same;
  logic       accept;
  logic       load;
  logic       set_overflow;
  result_t    decoded;
  result_t    result;
  logic       overflow_flag;

  // Map an active-low a..g pattern to digit, blank or error
  function automatic result_t decode(input logic [6:0] pat);
    result_t r;
    r = '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
    case (pat)
      7'b0000001: r.bcd = 4'd0;
      7'b1001111: r.bcd = 4'd1;
      7'b0010010: r.bcd = 4'd2;
      7'b0000110: r.bcd = 4'd3;
      7'b1001100: r.bcd = 4'd4;
      7'b0100100: r.bcd = 4'd5;
      7'b0100000: r.bcd = 4'd6;
      7'b0001111: r.bcd = 4'd7;
      7'b0000000: r.bcd = 4'd8;
      7'b0000100: r.bcd = 4'd9;
      BLANK_PAT:  r.blank = 1'b1;
      default:    r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Stability counter and accept detection; a pattern is accepted once, on
  // the edge its count first reaches the threshold, unless it repeats the
  // previously accepted pattern
  always_comb begin
    same       = (bus.seg_n == sample);
    count_next = 8'd0;
    if (same) begin
      count_next = (stable_count == STABLE_MAX) ? stable_count : stable_count + 8'd1;
    end
    accept  = same && (stable_count != STABLE_MAX) && (count_next == STABLE_MAX) &&
              (last_empty || (sample != last_pattern));
    decoded = decode(sample);
  end

  // Sample register, stability counter and last-accepted pattern
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample       <= BLANK_PAT;
      stable_count <= 8'd0;
      last_pattern <= BLANK_PAT;
      last_empty   <= 1'b1;
    end else begin
      sample       <= bus.seg_n;
      stable_count <= count_next;
      if (accept) begin
        last_pattern <= sample;
        last_empty   <= 1'b0;
      end
    end
  end

  // Output register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: load when there is room (or room is being freed this edge),
  // otherwise drop the new result and flag the overflow
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    set_overflow = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          if (bus.out_ready) begin
            load = 1'b1;
          end else begin
            set_overflow = 1'b1;
          end
        end else if (bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Result fields and sticky overflow; fields keep their values once consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result        <= '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
      overflow_flag <= 1'b0;
    end else begin
      if (load) begin
        result <= decoded;
      end
      if (set_overflow) begin
        overflow_flag <= 1'b1;
      end
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Count accepted error patterns, dropped ones included, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else if (accept && decoded.err && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.err_count = err_count_q;
`endif

  assign bus.out_valid = (state == FULL);
  assign bus.out_bcd   = result.bcd;
  assign bus.out_blank = result.blank;
  assign bus.out_err   = result.err;
  assign bus.overflow  = overflow_flag;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed testbench for seg7_capture_decoder (default STABLE_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg7_capture_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [5:0] res_q[$];

  seg7_capture_decoder_if bus_if ();

  seg7_capture_decoder #(.STABLE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.master)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Hold a pattern for n cycles, logging every handshake as {err,blank,bcd}
  task automatic hold_pattern(input logic [6:0] p, input int n);
    bus_if.seg_n = p;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_if.out_valid && bus_if.out_ready)
        res_q.push_back({bus_if.out_err, bus_if.out_blank, bus_if.out_bcd});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.seg_n = 7'b0010010;
    bus_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus_if.out_valid); end
    checks++; if (bus_if.out_bcd !== 4'd0) begin failures++; $display("[TB] FAIL reset_bcd got=%0d exp=0", bus_if.out_bcd); end
    checks++; if ({bus_if.out_blank, bus_if.out_err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {bus_if.out_blank, bus_if.out_err}); end
    checks++; if (bus_if.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", bus_if.overflow); end
`ifdef SEG7_ERR_COUNT_EN
    checks++; if (bus_if.err_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_err_count got=%0d exp=0", bus_if.err_count); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_digit;
    repeat (4) @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early got=%b exp=0", bus_if.out_valid); end
    @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency_edge5 got=%b exp=1", bus_if.out_valid); end
    checks++; if ({bus_if.out_err, bus_if.out_blank, bus_if.out_bcd} !== 6'b00_0010) begin failures++; $display("[TB] FAIL digit2 got=%b exp=000010", {bus_if.out_err, bus_if.out_blank, bus_if.out_bcd}); end
    repeat (10) @(negedge clk);
    checks++; if (bus_if.overflow !== 1'b0) begin failures++; $display("[TB] FAIL held_no_reemit overflow got=%b exp=0", bus_if.overflow); end
    checks++; if (bus_if.out_bcd !== 4'd2) begin failures++; $display("[TB] FAIL held_bcd got=%0d exp=2", bus_if.out_bcd); end
  endtask

  task automatic test_sequence;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL consume2 got=%b exp=0", bus_if.out_valid); end
    res_q.delete();
    for (int d = 0; d < 10; d++) hold_pattern(digit_pat(d), 6);
    checks++; if (res_q.size() !== 10) begin failures++; $display("[TB] FAIL seq_count got=%0d exp=10", res_q.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < res_q.size()) begin
        checks++; if (res_q[i] !== {2'b00, 4'(i)}) begin failures++; $display("[TB] FAIL seq_digit%0d got=%b exp=%b", i, res_q[i], {2'b00, 4'(i)}); end
      end
    end
    checks++; if (bus_if.overflow !== 1'b0) begin failures++; $display("[TB] FAIL seq_overflow got=%b exp=0", bus_if.overflow); end
  endtask

  task automatic test_glitch_blank;
    res_q.delete();
    hold_pattern(7'b1001111, 6);
    checks++; if (res_q.size() !== 1 || res_q[0] !== 6'b00_0001) begin failures++; $display("[TB] FAIL glitch_first got_n=%0d exp_n=1", res_q.size()); end
    res_q.delete();
    hold_pattern(7'b0000000, 2);
    hold_pattern(7'b1001111, 8);
    checks++; if (res_q.size() !== 0) begin failures++; $display("[TB] FAIL glitch_no_result got=%0d exp=0", res_q.size()); end
    hold_pattern(7'b1111111, 6);
    checks++; if (res_q.size() !== 1 || res_q[0] !== 6'b01_0000) begin failures++; $display("[TB] FAIL blank got_n=%0d got=%b exp=010000", res_q.size(), (res_q.size() > 0) ? res_q[0] : 6'b0); end
  endtask

  task automatic test_error;
    res_q.delete();
    hold_pattern(7'b1110000, 6);
    checks++; if (res_q.size() !== 1 || res_q[0] !== 6'b10_0000) begin failures++; $display("[TB] FAIL error got_n=%0d got=%b exp=100000", res_q.size(), (res_q.size() > 0) ? res_q[0] : 6'b0); end
`ifdef SEG7_ERR_COUNT_EN
    checks++; if (bus_if.err_count !== 8'd1) begin failures++; $display("[TB] FAIL err_count got=%0d exp=1", bus_if.err_count); end
`endif
  endtask

  task automatic test_overflow;
    bus_if.out_ready = 1'b0;
    hold_pattern(digit_pat(3), 6);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_bcd !== 4'd3) begin failures++; $display("[TB] FAIL ovf_first got=%b/%0d exp=1/3", bus_if.out_valid, bus_if.out_bcd); end
    hold_pattern(digit_pat(5), 6);
    checks++; if (bus_if.out_bcd !== 4'd3) begin failures++; $display("[TB] FAIL ovf_keep got=%0d exp=3", bus_if.out_bcd); end
    checks++; if (bus_if.overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", bus_if.overflow); end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drain got=%b exp=0", bus_if.out_valid); end
    res_q.delete();
    hold_pattern(digit_pat(5), 10);
    checks++; if (res_q.size() !== 0) begin failures++; $display("[TB] FAIL ovf_no_reemit got=%0d exp=0", res_q.size()); end
    checks++; if (bus_if.overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", bus_if.overflow); end
  endtask

  task automatic test_reset_midway;
    bus_if.out_ready = 1'b0;
    hold_pattern(digit_pat(4), 6);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_bcd !== 4'd4) begin failures++; $display("[TB] FAIL mid_full got=%b/%0d exp=1/4", bus_if.out_valid, bus_if.out_bcd); end
    hold_pattern(digit_pat(7), 2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus_if.out_valid, bus_if.out_err, bus_if.out_blank, bus_if.out_bcd, bus_if.overflow} !== 8'd0) begin failures++; $display("[TB] FAIL mid_reset got=%b exp=00000000", {bus_if.out_valid, bus_if.out_err, bus_if.out_blank, bus_if.out_bcd, bus_if.overflow}); end
`ifdef SEG7_ERR_COUNT_EN
    checks++; if (bus_if.err_count !== 8'd0) begin failures++; $display("[TB] FAIL mid_reset_err_count got=%0d exp=0", bus_if.err_count); end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_early got=%b exp=0", bus_if.out_valid); end
    @(negedge clk);
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_bcd !== 4'd7) begin failures++; $display("[TB] FAIL mid_digit7 got=%b/%0d exp=1/7", bus_if.out_valid, bus_if.out_bcd); end
  endtask

  // Run all scenarios in order, then report
  initial begin
    checks   = 0;
    failures = 0;
    @(negedge clk);
    test_reset();
    test_single_digit();
    test_sequence();
    test_glitch_blank();
    test_error();
    test_overflow();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
